dom_and_feeder: RTL
===================

Name: dom_and_feeder

Overview:
- Sequencing stage directly upstream and downstream of the 2-share DOM AND gadget.
- Accepts an unmasked operand pair, splits it into D Boolean shares using fresh PRNG bits, and supplies the gadget's share inputs and rin.
- Drives the gadget enable and waits for its done flag, then captures the output shares, optionally recombines them, and presents the result on a valid/ready handshake.

Parameters:
- D, 2, share count; must match the gadget's D.
- RAND_SIZE, D*(D-1)/2, width of the gadget rin bus (localparam, not overridable).
- RAND_BITS, 2*(D-1)+RAND_SIZE, fresh bits consumed per operation; must be ≤32, elaborate-time error otherwise.
- MAX_WAIT, 8, enabled cycles allowed before a timeout is declared.
- UNMASK, 1, 1 = drive y with the XOR of the result shares; 0 = y tied 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- seed_load  in  1  load LFSR from seed; honoured only in IDLE
- seed  in  32  LFSR seed; an all-zero value is replaced by 32'h1
- in_valid  in  1  operand handshake valid
- in_ready  out  1  high only in IDLE
- a  in  1  plain operand a
- b  in  1  plain operand b
- and_ina  out  D  share vector of a to the gadget
- and_inb  out  D  share vector of b to the gadget
- and_rin  out  RAND_SIZE  gadget randomness
- and_enable  out  1  gadget enable
- and_done  in  1  gadget done flag
- and_out  in  D  gadget output shares
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- y_shares  out  D  captured result shares
- y  out  1  recombined result (UNMASK=1)
- busy  out  1  state ≠ IDLE
- err_timeout  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state=IDLE; LFSR=32'h1
  - and_ina, and_inb, and_rin, and_enable, y_shares, y, out_valid and err_timeout all 0
  - wait counter 0
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances one step per accepted operation only.
  - Bits [RAND_BITS-1:0] are used, taken from the value before the step.
- IDLE:
  - in_ready=1.
  - seed_load has priority over in_valid in the same cycle; the seed is loaded and the operand is not accepted that cycle.
  - in_valid & ~seed_load → MASK; a and b are registered.
- MASK, one cycle:
  - Share k (k=0..D-2) of a = LFSR bit k; share D-1 = a ^ XOR of the other a shares.
  - b uses bits D-1..2D-3 the same way.
  - and_rin = the next RAND_SIZE bits.
  - All are registered and held stable until the next MASK.
  - → EXEC.
- EXEC:
  - and_enable=1 and the wait counter increments each cycle.
  - and_done is ignored in the first EXEC cycle, because the gadget holds a stale done from the previous operation.
  - From the second cycle on, and_done=1 → capture and_out into y_shares, set y=^and_out, deassert and_enable next cycle, → RESULT.
  - Wait counter reaching MAX_WAIT without done → err_timeout=1, and_enable=0, → IDLE; no result is produced.
  - Nominal latency: accept edge → out_valid in 5 cycles (MASK 1, EXEC 3 gadget cycles + 1 capture).
- RESULT:
  - out_valid=1; y and y_shares are held stable.
  - out_ready=1 → out_valid=0, → IDLE.
  - A new operand cannot be accepted in the same cycle (no bypass).
- rst_n asserted mid-operation: everything returns to reset values immediately; a partially computed result is discarded.
- Share outputs are updated only in MASK; do not glitch them through combinational paths. Registered outputs are required for masking security.

Decomposition:
- Shared package: LFSR width/taps constant, reset seed 32'h1, state enum {IDLE, MASK, EXEC, RESULT}.
- One sub-module: lfsr32_galois (load, step, value).
- Share splitting stays inline.

Test Plan:
- Seed 32'h1, a=1 b=1, gadget model with 3-cycle done, out_ready=1 → out_valid 5 cycles after accept, y=1, XOR(y_shares)=1.
- All four (a,b) combinations, 100 random seeds each → y=a&b every time; XOR(and_ina)=a and XOR(and_inb)=b every time.
- and_done stuck 1 from the previous op, real done on the 3rd cycle → feeder ignores the first-cycle done; correct y.
- and_done stuck 0 → err_timeout=1 after MAX_WAIT=8 EXEC cycles, state IDLE, out_valid never asserts.
- out_ready held 0 for 10 cycles → out_valid, y and y_shares stable, in_ready=0 throughout; release → IDLE next cycle.
- seed_load=1 with seed 0 and in_valid=1 together → LFSR=32'h1, operand not accepted; rst_n pulsed low during EXEC → all outputs 0 asynchronously.

Source files
------------

// File: rtl/dom_and_feeder_pkg.sv
// Shared types and constants for the DOM AND feeder: LFSR polynomial/seed and sequencing states.
// The LFSR is a 32-bit right-shift Galois register for x^32+x^22+x^2+x+1.
package dom_and_feeder_pkg;

  localparam int                LFSR_W    = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MASK   = 2'd1,
    EXEC   = 2'd2,
    RESULT = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the reset seed.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_SEED : s;
  endfunction

endpackage

// File: rtl/dom_and_feeder_lfsr32_galois.sv
// 32-bit Galois LFSR supplying fresh mask bits; load has priority over step.
// Value changes only on load or step, so the low OUT_W bits are a registered output.
module lfsr32_galois
  import dom_and_feeder_pkg::*;
#(
  parameter int OUT_W = LFSR_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [OUT_W-1:0]  o_value
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LFSR_SEED;
    end else if (i_load) begin
      r_state <= seed_fix(i_seed);
    end else if (i_step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_value = r_state[OUT_W-1:0];

endmodule

// File: rtl/dom_and_feeder.sv
// Splits a plain (a,b) pair into D Boolean shares, runs the DOM AND gadget and returns its shares.
// Accept-to-out_valid is 5 cycles with a 3-cycle gadget; in_ready only in IDLE, result held until out_ready.
module dom_and_feeder
  import dom_and_feeder_pkg::*;
#(
  parameter  int D         = 2,
  parameter  int MAX_WAIT  = 8,
  parameter  bit UNMASK    = 1'b1,
  localparam int RAND_SIZE = D * (D - 1) / 2,
  localparam int RAND_BITS = 2 * (D - 1) + RAND_SIZE
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 a,
  input  logic                 b,
  output logic [D-1:0]         and_ina,
  output logic [D-1:0]         and_inb,
  output logic [RAND_SIZE-1:0] and_rin,
  output logic                 and_enable,
  input  logic                 and_done,
  input  logic [D-1:0]         and_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D-1:0]         y_shares,
  output logic                 y,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  if (RAND_BITS > LFSR_W) begin : g_rand_bits_check
    $error("dom_and_feeder: RAND_BITS exceeds the 32-bit LFSR width");
  end
  if (D < 2) begin : g_share_count_check
    $error("dom_and_feeder: at least two shares are required");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_seed_ld;
  logic                  w_capture;
  logic                  w_timeout;

  logic                  r_a;
  logic                  r_b;
  logic [D-1:0]          r_ina;
  logic [D-1:0]          r_inb;
  logic [RAND_SIZE-1:0]  r_rin;
  logic                  r_en;
  logic [WAIT_W-1:0]     r_wait;
  logic [D-1:0]          r_y_shares;
  logic                  r_y;
  logic                  r_err;

  logic [RAND_BITS-1:0]  w_rand;
  logic [D-1:0]          w_ina;
  logic [D-1:0]          w_inb;
  logic [RAND_SIZE-1:0]  w_rin;
  logic                  w_acc_a;
  logic                  w_acc_b;

  lfsr32_galois #(
    .OUT_W (RAND_BITS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_seed_ld),
    .i_seed  (seed),
    .i_step  (r_state == MASK),
    .o_value (w_rand)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The first EXEC cycle (r_wait == 0) sees the gadget's stale done from the previous operation.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_seed_ld   = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (seed_load) begin
          w_seed_ld = 1'b1;
        end else if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = MASK;
        end
      end
      MASK: begin
        w_state_nxt = EXEC;
      end
      EXEC: begin
        if (and_done && (r_wait != '0)) begin
          w_capture   = 1'b1;
          w_state_nxt = RESULT;
        end else if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RESULT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shares 0..D-2 come straight from the LFSR; the last share folds in the plain operand.
  always_comb begin
    w_ina   = '0;
    w_inb   = '0;
    w_acc_a = r_a;
    w_acc_b = r_b;
    for (int k = 0; k < D - 1; k++) begin
      w_ina[k] = w_rand[k];
      w_inb[k] = w_rand[D - 1 + k];
      w_acc_a  = w_acc_a ^ w_rand[k];
      w_acc_b  = w_acc_b ^ w_rand[D - 1 + k];
    end
    w_ina[D-1] = w_acc_a;
    w_inb[D-1] = w_acc_b;
  end

  assign w_rin = w_rand[2*(D-1) +: RAND_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_ina      <= '0;
      r_inb      <= '0;
      r_rin      <= '0;
      r_en       <= 1'b0;
      r_wait     <= '0;
      r_y_shares <= '0;
      r_y        <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
      end
      if (r_state == MASK) begin
        r_ina  <= w_ina;
        r_inb  <= w_inb;
        r_rin  <= w_rin;
        r_en   <= 1'b1;
        r_wait <= '0;
      end
      if (r_state == EXEC) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_capture) begin
        r_y_shares <= and_out;
        r_y        <= UNMASK ? (^and_out) : 1'b0;
      end
      if (w_capture || w_timeout) begin
        r_en <= 1'b0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign out_valid   = (r_state == RESULT);
  assign and_ina     = r_ina;
  assign and_inb     = r_inb;
  assign and_rin     = r_rin;
  assign and_enable  = r_en;
  assign y_shares    = r_y_shares;
  assign y           = r_y;
  assign err_timeout = r_err;

endmodule
